// File: rtl/barrett_mod_accum.sv
// Modular accumulator for Barrett-reduced products: folds each t from [0,2q) into [0,q),
// sums len terms mod q, returns the result over valid/ready. Optional subtract mode: MOD_ACC_SUB_EN.
module barrett_mod_accum #(
  parameter int W     = 64,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [W-1:0]     q,
`ifdef MOD_ACC_SUB_EN
  input  logic             op_sub,
`endif
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             err_range
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     mod_q, mod_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             busy_q, busy_d;
`ifdef MOD_ACC_SUB_EN
  logic             op_sub_q, op_sub_d;
`endif

  logic [W-1:0]     t_adj;
  logic [W-1:0]     acc_new;
  logic [W:0]       sum_w;
  logic             beat;
  logic             over_range;
  logic [LEN_W-1:0] cnt_inc;

  // Datapath: single-subtract fold of t, then one modular add (or subtract).
  // Final differences are taken with W-bit wraparound; the W+1-bit compares pick the branch.
  always_comb begin
    t_adj      = (in_data >= mod_q) ? in_data - mod_q : in_data;
    over_range = ({1'b0, in_data} >= {mod_q, 1'b0});
    sum_w      = {1'b0, acc_q} + {1'b0, t_adj};
    acc_new    = (sum_w >= {1'b0, mod_q}) ? acc_q + t_adj - mod_q : acc_q + t_adj;
`ifdef MOD_ACC_SUB_EN
    if (op_sub_q) begin
      acc_new = (acc_q >= t_adj) ? acc_q - t_adj : acc_q + mod_q - t_adj;
    end
`endif
    beat    = in_valid & in_ready_q;
    cnt_inc = cnt_q + LEN_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mod_d       = mod_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
`ifdef MOD_ACC_SUB_EN
    op_sub_d    = op_sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          mod_d  = q;
          len_d  = len;
          acc_d  = '0;
          cnt_d  = '0;
          err_d  = 1'b0;
          busy_d = 1'b1;
`ifdef MOD_ACC_SUB_EN
          op_sub_d = op_sub;
`endif
          if (len == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_data_d  = '0;
          end else begin
            state_d    = ACCUM;
            in_ready_d = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = acc_new;
          cnt_d = cnt_inc;
          if (over_range) err_d = 1'b1;
          // cnt < len here, so cnt+1 never wraps even for len = 2^LEN_W-1
          if (cnt_inc == len_q) begin
            state_d     = DONE;
            out_data_d  = acc_new;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mod_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
`ifdef MOD_ACC_SUB_EN
      op_sub_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mod_q       <= mod_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
`ifdef MOD_ACC_SUB_EN
      op_sub_q    <= op_sub_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign err_range = err_q;

endmodule

// File: tb/tb_barrett_mod_accum.sv
// Directed bench for barrett_mod_accum: hand-computed modular sums, handshake and boundary cases.
module tb_barrett_mod_accum;
  localparam int W     = 64;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, out_ready, op_sub;
  logic [LEN_W-1:0] len;
  logic [W-1:0]     q, in_data;
  logic             in_ready, out_valid, busy, err_range;
  logic [W-1:0]     out_data;

  int total = 0;
  int bad   = 0;

  localparam logic [W-1:0] QBIG = 64'hFFFF_FFFF_FFFF_FFC5;

  always #5 clk = ~clk;

  barrett_mod_accum #(.W(W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .q(q),
`ifdef MOD_ACC_SUB_EN
    .op_sub(op_sub),
`endif
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .err_range(err_range)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [W-1:0] qv, input logic [LEN_W-1:0] lv, input logic sub);
    q = qv; len = lv; op_sub = sub; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one beat and hold it until the edge that accepts it.
  task automatic send_beat(input logic [W-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL beat_wait: in_ready never rose for data %0d", d);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({in_ready, out_valid, busy, err_range} !== 4'b0000 || out_data !== '0) begin
      bad++;
      $display("FAIL reset: rdy=%b vld=%b busy=%b err=%b data=%0d, want all 0",
               in_ready, out_valid, busy, err_range, out_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_data = 64'd7;
    tick();
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_ignore: rdy=%b busy=%b, want 0 0", in_ready, busy);
    end
    in_valid = 1'b0;
    start_job(64'd97, 16'd3, 1'b0);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL accum_entry: rdy=%b busy=%b, want 1 1", in_ready, busy);
    end
    send_beat(64'd50);
    send_beat(64'd60);
    send_beat(64'd96);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 64'd12 || in_ready !== 1'b0 || err_range !== 1'b0) begin
      bad++;
      $display("FAIL b2b_result: vld=%b data=%0d rdy=%b err=%b, want 1 12 0 0",
               out_valid, out_data, in_ready, err_range);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_release: vld=%b busy=%b, want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_fold();
    start_job(64'd97, 16'd2, 1'b0);
    send_beat(64'd150);
    send_beat(64'd100);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 64'd56 || err_range !== 1'b0) begin
      bad++;
      $display("FAIL fold: vld=%b data=%0d err=%b, want 1 56 0", out_valid, out_data, err_range);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_range();
    start_job(64'd97, 16'd1, 1'b0);
    send_beat(64'd200);
    in_valid = 1'b0;
    // t' = 103, acc = 103 - 97 = 6
    total++;
    if (err_range !== 1'b1 || out_data !== 64'd6) begin
      bad++;
      $display("FAIL range_set: err=%b data=%0d, want 1 6", err_range, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    total++;
    if (err_range !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL range_sticky: err=%b busy=%b, want 1 0", err_range, busy);
    end
    start_job(64'd97, 16'd1, 1'b0);
    total++;
    if (err_range !== 1'b0) begin
      bad++;
      $display("FAIL range_clear: err=%b, want 0", err_range);
    end
    send_beat(64'd5);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_len_zero();
    start_job(64'd97, 16'd0, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_data !== 64'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL len0: vld=%b data=%0d busy=%b, want 1 0 1", out_valid, out_data, busy);
    end
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0); len = 16'd3; q = 64'd11;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 64'd0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL len0_hold%0d: vld=%b data=%0d rdy=%b, want 1 0 0",
                 i, out_valid, out_data, in_ready);
      end
    end
    start = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL done_start_ignored: vld=%b busy=%b rdy=%b, want 0 0 0",
               out_valid, busy, in_ready);
    end
    // Held out_ready: exactly one transfer
    out_ready = 1'b1;
    start_job(64'd97, 16'd0, 1'b0);
    tick();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL one_transfer: vld=%b busy=%b, want 0 0", out_valid, busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wide_carry();
    for (int pass = 0; pass < 2; pass++) begin
      start_job(QBIG, 16'd2, 1'b0);
      send_beat(QBIG - 64'd1);
      if (pass == 1) begin
        in_valid = 1'b0;
        repeat (3) tick();
      end
      send_beat(QBIG - 64'd1);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== 64'hFFFF_FFFF_FFFF_FFC3) begin
        bad++;
        $display("FAIL wide_carry%0d: vld=%b data=%h, want 1 ffffffffffffffc3",
                 pass, out_valid, out_data);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_rst_mid();
    start_job(64'd97, 16'd3, 1'b0);
    send_beat(64'd40);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, busy, err_range} !== 4'b0000 || out_data !== '0) begin
      bad++;
      $display("FAIL rst_mid: rdy=%b vld=%b busy=%b err=%b data=%0d, want all 0",
               in_ready, out_valid, busy, err_range, out_data);
    end
    start_job(64'd97, 16'd1, 1'b0);
    send_beat(64'd5);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 64'd5) begin
      bad++;
      $display("FAIL after_rst: vld=%b data=%0d, want 1 5", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

`ifdef MOD_ACC_SUB_EN
  task automatic test_sub();
    start_job(64'd97, 16'd1, 1'b1);
    send_beat(64'd5);
    in_valid = 1'b0;
    total++;
    if (out_data !== 64'd92) begin
      bad++;
      $display("FAIL sub1: data=%0d, want 92", out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start_job(64'd97, 16'd2, 1'b1);
    send_beat(64'd5);
    send_beat(64'd10);
    in_valid = 1'b0;
    total++;
    if (out_data !== 64'd82) begin
      bad++;
      $display("FAIL sub2: data=%0d, want 82", out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0;
    len = '0; q = '0; in_data = '0;
    test_reset();
    test_back_to_back();
    test_fold();
    test_range();
    test_len_zero();
    test_wide_carry();
    test_rst_mid();
`ifdef MOD_ACC_SUB_EN
    test_sub();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, total=%0d", total);
    $fatal(1);
  end
endmodule
